// File: rtl/regfile_dump_reader_if.sv
// Stream/bus bundle between the dump reader, the register file it reads and its consumer.
// master is the reader's view; slave is the register file plus consumer side.
interface regfile_dump_reader_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic [WIDTH-1:0]      out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start,
        input  abort,
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_addr,
        output out_valid,
        input  out_ready,
        output busy,
        output done
    );

    modport slave (
        output start,
        output abort,
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_addr,
        input  out_valid,
        output out_ready,
        input  busy,
        input  done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register-file addresses 0..DEPTH-1 on a start pulse and presents each
// captured word with its address on a valid/ready stream.
module regfile_dump_reader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_dump_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_last;

    assign w_accept = r_out_valid && bus.out_ready;
    assign w_last   = (r_addr == LAST_ADDR);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers; the reset branch clears the captured
    // word too, since it is a visible output with a defined reset value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (r_state != S_IDLE && bus.abort) begin
            // Cancel keeps the last presented word but drops the stream.
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_out_data  <= bus.rd_data;
                    r_out_addr  <= r_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end

                S_PRESENT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr   = r_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
